// File: rtl/learn_mode_controller_pkg.sv
// Shared types for the piano learn-mode controller:
// state encoding, screen codes, key bit order and note codes.
package learn_mode_controller_pkg;

  typedef enum logic [1:0] {
    ST_HOME  = 2'b00,
    ST_FREE  = 2'b01,
    ST_LEARN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] SCR_HOME  = 2'b00;
  localparam logic [1:0] SCR_FREE  = 2'b01;
  localparam logic [1:0] SCR_LEARN = 2'b10;
  localparam logic [1:0] SCR_DONE  = 2'b11;

  localparam int NUM_KEYS = 7;
  localparam int KEY_C = 0;
  localparam int KEY_D = 1;
  localparam int KEY_E = 2;
  localparam int KEY_F = 3;
  localparam int KEY_G = 4;
  localparam int KEY_A = 5;
  localparam int KEY_B = 6;

  typedef enum logic [2:0] {
    NOTE_C = 3'd0,
    NOTE_D = 3'd1,
    NOTE_E = 3'd2,
    NOTE_F = 3'd3,
    NOTE_G = 3'd4,
    NOTE_A = 3'd5,
    NOTE_B = 3'd6
  } note_e;

  function automatic logic [NUM_KEYS-1:0] note_onehot(
    input logic [2:0] code
  );
    note_onehot = NUM_KEYS'(1) << code;
  endfunction

  function automatic logic [1:0] screen_of(input state_e s);
    unique case (s)
      ST_HOME:  screen_of = SCR_HOME;
      ST_FREE:  screen_of = SCR_FREE;
      ST_LEARN: screen_of = SCR_LEARN;
      ST_DONE:  screen_of = SCR_DONE;
      default:  screen_of = SCR_HOME;
    endcase
  endfunction

endpackage

// File: rtl/learn_mode_controller_song_rom.sv
// 32-entry note-code ROM; holds Mary Had a Little Lamb,
// unused tail entries read as C.
module song_rom
  import learn_mode_controller_pkg::*;
(
  input  logic [4:0] addr_i,
  output logic [2:0] code_o
);

  localparam note_e SONG [32] = '{
    NOTE_E, NOTE_D, NOTE_C, NOTE_D,
    NOTE_E, NOTE_E, NOTE_E, NOTE_D,
    NOTE_D, NOTE_D, NOTE_E, NOTE_G,
    NOTE_G, NOTE_E, NOTE_D, NOTE_C,
    NOTE_D, NOTE_E, NOTE_E, NOTE_E,
    NOTE_E, NOTE_D, NOTE_D, NOTE_E,
    NOTE_D, NOTE_C, NOTE_C, NOTE_C,
    NOTE_C, NOTE_C, NOTE_C, NOTE_C
  };

  assign code_o = SONG[addr_i];

endmodule

// File: rtl/learn_mode_controller.sv
// Home / free-play / learn-song / done mode sequencer with
// synchronized inputs and frame-aligned display outputs.
module learn_mode_controller
  import learn_mode_controller_pkg::*;
#(
  parameter int SONG_LEN    = 26,
  parameter int DONE_FRAMES = 120
) (
  input  logic       iVGA_CLK,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [6:0] keys,
  input  logic       free_play_button,
  input  logic       learn_song_button,
  output logic [1:0] screen_sel,
  output logic [6:0] target_note,
  output logic [4:0] note_idx,
  output logic [7:0] mistakes,
  output logic       song_done
);

  localparam logic [4:0] LAST_IDX = 5'(SONG_LEN - 1);
  localparam logic [7:0] DONE_LD  = 8'(DONE_FRAMES);

  // {learn, free, keys} travel through one sync/edge chain
  logic [8:0] raw;
  logic [8:0] s1_q, s2_q, prev_q, rise;

  assign raw  = {learn_song_button, free_play_button, keys};
  assign rise = s2_q & ~prev_q;

  logic       key_ev, fp_ev, ls_ev;
  logic [6:0] key_vec;

  assign key_ev  = |rise[6:0];
  assign fp_ev   = rise[7];
  assign ls_ev   = rise[8];
  assign key_vec = s2_q[6:0];

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] mis_q, mis_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] tgt_q, tgt_d;
  logic [1:0] scr_sh_q;
  logic [6:0] tgt_sh_q;
  logic [2:0] rom_code;

  song_rom u_rom (
    .addr_i (idx_q),
    .code_o (rom_code)
  );

  assign tgt_d = (state_q == ST_LEARN)
               ? note_onehot(rom_code) : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_HOME: begin
        if (fp_ev) begin
          state_d = ST_FREE;
        end else if (ls_ev) begin
          state_d = ST_LEARN;
          idx_d   = '0;
          mis_d   = '0;
        end
      end
      ST_FREE: begin
        if (fp_ev) begin
          state_d = ST_HOME;
        end else if (ls_ev) begin
          state_d = ST_LEARN;
          idx_d   = '0;
          mis_d   = '0;
        end
      end
      ST_LEARN: begin
        if (fp_ev) begin
          state_d = ST_HOME;
        end else if (ls_ev) begin
          idx_d = '0;
          mis_d = '0;
        end else if (key_ev) begin
          if (key_vec == tgt_q) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              cnt_d   = DONE_LD;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end else if (mis_q != 8'hFF) begin
            mis_d = mis_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        if (fp_ev || ls_ev) begin
          state_d = ST_HOME;
        end else if (frame_start) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = '0;
            state_d = ST_HOME;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_HOME;
    endcase
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      state_q  <= ST_HOME;
      idx_q    <= '0;
      mis_q    <= '0;
      cnt_q    <= '0;
      tgt_q    <= '0;
      scr_sh_q <= SCR_HOME;
      tgt_sh_q <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      // display only changes at frame boundaries
      if (frame_start) begin
        scr_sh_q <= screen_of(state_q);
        tgt_sh_q <= tgt_q;
      end
    end
  end

  assign screen_sel  = scr_sh_q;
  assign target_note = tgt_sh_q;
  assign note_idx    = idx_q;
  assign mistakes    = mis_q;
  assign song_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_learn_mode_controller.sv
// Randomized + directed bench for learn_mode_controller
// against a behavioural mode/score model.
module tb_learn_mode_controller;

  localparam int FP     = 8;
  localparam int SLEN   = 26;
  localparam int DFRAME = 120;
  localparam int M_HOME  = 0;
  localparam int M_FREE  = 1;
  localparam int M_LEARN = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [6:0] keys;
  logic       fpb, lsb;
  logic [1:0] screen_sel;
  logic [6:0] target_note;
  logic [4:0] note_idx;
  logic [7:0] mistakes;
  logic       song_done;

  always #5 clk = ~clk;

  learn_mode_controller dut (
    .iVGA_CLK          (clk),
    .reset             (reset),
    .frame_start       (frame_start),
    .keys              (keys),
    .free_play_button  (fpb),
    .learn_song_button (lsb),
    .screen_sel        (screen_sel),
    .target_note       (target_note),
    .note_idx          (note_idx),
    .mistakes          (mistakes),
    .song_done         (song_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  string SONG  = "edcdeeedddeggedcdeeeeddedc";
  string NAMES = "cdefgab";

  function automatic int code_of(input int i);
    byte ch;
    ch = SONG[i];
    code_of = 0;
    for (int k = 0; k < 7; k++)
      if (NAMES[k] == ch) code_of = k;
  endfunction

  // model: history of sampled raw inputs and the game rules
  logic [8:0] r0, r1, r2;
  int m_st, m_idx, m_mis, m_cnt, m_live, m_scr, m_tgt;
  int fc = 0;

  task automatic model_step();
    logic [8:0] ev;
    int target;
    if (reset) begin
      r0 = '0; r1 = '0; r2 = '0;
      m_st = M_HOME; m_idx = 0; m_mis = 0; m_cnt = 0;
      m_live = 0; m_scr = 0; m_tgt = 0;
      return;
    end
    ev = r1 & ~r2;
    if (frame_start) begin
      m_scr = m_st;
      m_tgt = m_live;
    end
    target = 1 << code_of(m_idx);
    m_live = (m_st == M_LEARN) ? target : 0;
    case (m_st)
      M_HOME, M_FREE: begin
        if (ev[7]) m_st = (m_st == M_HOME) ? M_FREE : M_HOME;
        else if (ev[8]) begin
          m_st = M_LEARN; m_idx = 0; m_mis = 0;
        end
      end
      M_LEARN: begin
        if (ev[7]) m_st = M_HOME;
        else if (ev[8]) begin
          m_idx = 0; m_mis = 0;
        end else if (|ev[6:0]) begin
          if (int'(r1[6:0]) == target) begin
            if (m_idx == SLEN - 1) begin
              m_st = M_DONE; m_cnt = DFRAME;
            end else m_idx++;
          end else if (m_mis < 255) m_mis++;
        end
      end
      default: begin
        if (ev[7] || ev[8]) m_st = M_HOME;
        else if (frame_start) begin
          m_cnt--;
          if (m_cnt <= 0) begin
            m_cnt = 0; m_st = M_HOME;
          end
        end
      end
    endcase
    r2 = r1; r1 = r0; r0 = {lsb, fpb, keys};
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("screen_sel", 32'(screen_sel), m_scr);
    check("target_note", 32'(target_note), m_tgt);
    check("note_idx", 32'(note_idx), m_idx);
    check("mistakes", 32'(mistakes), m_mis);
    check("song_done", 32'(song_done), 32'(m_st == M_DONE));
    fc++;
    frame_start = (fc % FP == FP - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input logic [6:0] v);
    keys = v;
    idle(4);
    keys = '0;
    idle(4);
  endtask

  task automatic pulse_btn(input logic fp, input logic ls);
    fpb = fp; lsb = ls;
    cyc();
    fpb = 1'b0; lsb = 1'b0;
    idle(6);
  endtask

  function automatic logic [6:0] note_vec(input int i);
    note_vec = 7'(1 << code_of(i));
  endfunction

  initial begin
    reset = 1'b1; frame_start = 1'b0;
    keys = '0; fpb = 1'b0; lsb = 1'b0;
    idle(3);
    check("rst_screen", 32'(screen_sel), 0);
    check("rst_idx", 32'(note_idx), 0);
    check("rst_done", 32'(song_done), 0);
    reset = 1'b0;
    idle(5);

    pulse_btn(1'b0, 1'b1);
    idle(2 * FP);
    check("learn_screen", 32'(screen_sel), 2);
    check("learn_target", 32'(target_note), 32'h04);
    check("learn_idx", 32'(note_idx), 0);
    check("learn_mis", 32'(mistakes), 0);

    press(7'b0000010);
    check("wrong_mis", 32'(mistakes), 1);
    check("wrong_idx", 32'(note_idx), 0);
    press(7'b0000100);
    check("right_idx", 32'(note_idx), 1);
    idle(2 * FP);
    check("next_target", 32'(target_note), 32'h02);

    press(7'b0000010);
    press(7'b0000011);
    check("chord_mis", 32'(mistakes), 2);
    check("chord_idx", 32'(note_idx), 2);
    keys = 7'b0000001;
    idle(1000);
    keys = '0;
    idle(4);
    check("hold_idx", 32'(note_idx), 3);
    check("hold_mis", 32'(mistakes), 2);
    keys = 7'b0000010;
    idle(6);
    keys = 7'b0000110;
    idle(6);
    keys = '0;
    idle(4);
    check("second_key_idx", 32'(note_idx), 4);
    check("second_key_mis", 32'(mistakes), 3);

    pulse_btn(1'b0, 1'b1);
    check("restart_idx", 32'(note_idx), 0);
    check("restart_mis", 32'(mistakes), 0);
    for (int i = 0; i < SLEN; i++) press(note_vec(i));
    check("song_done", 32'(song_done), 1);
    idle(2 * FP);
    check("done_screen", 32'(screen_sel), 3);
    idle(100 * FP);
    check("done_hold", 32'(song_done), 1);
    idle(20 * FP);
    check("done_exit", 32'(song_done), 0);
    check("done_home", 32'(screen_sel), 0);

    pulse_btn(1'b1, 1'b1);
    idle(2 * FP);
    check("both_home", 32'(screen_sel), 1);
    pulse_btn(1'b1, 1'b1);
    idle(2 * FP);
    check("both_free", 32'(screen_sel), 0);

    pulse_btn(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) press(7'b0000001);
    check("sat_mis", 32'(mistakes), 255);
    check("sat_idx", 32'(note_idx), 0);

    pulse_btn(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) press(note_vec(i));
    check("mid_idx", 32'(note_idx), 10);
    lsb = 1'b1;
    reset = 1'b1;
    cyc();
    check("mid_rst_idx", 32'(note_idx), 0);
    check("mid_rst_mis", 32'(mistakes), 0);
    check("mid_rst_tgt", 32'(target_note), 0);
    reset = 1'b0;
    cyc();
    check("post_rst_done", 32'(song_done), 0);
    lsb = 1'b0;
    idle(10);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        if (m_st == M_LEARN) press(note_vec(m_idx));
        else press(7'($urandom_range(1, 127)));
      end else if (r < 80) press(7'($urandom_range(1, 127)));
      else if (r < 87) pulse_btn(1'b0, 1'b1);
      else if (r < 92) pulse_btn(1'b1, 1'b0);
      else if (r < 95) pulse_btn(1'b1, 1'b1);
      else idle($urandom_range(1, 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/learn_mode_controller.md
LEARN_MODE_CONTROLLER -- requirements
Module: learn_mode_controller

Interface
REQ-001 Parameter SONG_LEN, default 26: number of notes in the stored song, range 1..32.
REQ-002 Parameter DONE_FRAMES, default 120: frames the DONE screen is held before returning to HOME, range 1..255.
REQ-003 iVGA_CLK  in  1  sole clock (pixel clock); all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 frame_start  in  1  one-cycle pulse at the start of each frame, from the sync generator.
REQ-006 keys  in  7  raw key levels, bit0=c, bit1=d, bit2=e, bit3=f, bit4=g, bit5=a, bit6=b.
REQ-007 free_play_button  in  1  raw level request for free-play mode.
REQ-008 learn_song_button  in  1  raw level request for learn-song mode.
REQ-009 screen_sel  out  2  display image select: 00 home, 01 free play, 10 learn, 11 done.
REQ-010 target_note  out  7  one-hot key to highlight (same bit order as keys); zero outside LEARN.
REQ-011 note_idx  out  5  position of the current target note in the song.
REQ-012 mistakes  out  8  wrong-key count for the current song attempt.
REQ-013 song_done  out  1  high while in DONE.

Function
REQ-014 keys, free_play_button and learn_song_button SHALL each pass through a 2-flop synchronizer followed by rising-edge detection; only synchronized rising edges are events.
REQ-015 FSM states SHALL be HOME, FREE, LEARN, DONE.
REQ-016 HOME: free_play_button edge -> FREE; learn_song_button edge -> LEARN with note_idx=0 and mistakes=0; both in the same cycle -> FREE.
REQ-017 FREE: learn_song_button edge -> LEARN (note_idx and mistakes cleared); free_play_button edge -> HOME; both in the same cycle -> HOME; key events are ignored.
REQ-018 LEARN: on any key event, if the synchronized key vector equals target_note exactly, note_idx increments; otherwise mistakes increments, saturating at 255.
REQ-019 LEARN: a correct key on note_idx = SONG_LEN-1 SHALL go to DONE and load the frame counter with DONE_FRAMES.
REQ-020 LEARN: free_play_button edge -> HOME; learn_song_button edge restarts the song (note_idx=0, mistakes=0, stay LEARN). A button edge takes priority over a key event in the same cycle.
REQ-021 DONE: the frame counter decrements on each frame_start; transition to HOME when it reaches 0 on a frame_start; any button edge -> HOME immediately; mistakes holds its value.
REQ-022 target_note SHALL be the one-hot decode of the song ROM entry at note_idx, registered, 1 cycle after note_idx changes.
REQ-023 screen_sel and target_note SHALL update only in the cycle after frame_start (shadow registers copy the live values on frame_start); note_idx, mistakes and song_done SHALL update immediately.
REQ-024 Key events are counted edge-wise: a held key counts once; a second key pressed while the first is held is evaluated against the full synchronized vector.
REQ-025 Latency: a raw input edge to state change is 3 cycles (2 sync + 1 edge detect); to screen_sel it is that plus wait to the next frame_start plus 1.

Reset
REQ-026 While reset is high at a clock edge: state=HOME, screen_sel=00, target_note=0, note_idx=0, mistakes=0, song_done=0, frame counter=0, synchronizer and edge-detect flops=0.
REQ-027 Reset asserted mid-song SHALL abandon progress with no partial update; the first cycle after deassertion SHALL produce no events even if inputs are held high.

Structure
REQ-028 Shared package SHALL hold: state encoding, screen_sel codes (HOME=00, FREE=01, LEARN=10, DONE=11), the key bit-order constants, and the 3-bit note code (c=0 .. b=6).
REQ-029 Sub-module song_rom SHALL be a 32x3 combinational lookup of note codes, defaulting to Mary Had a Little Lamb (e d c d e e e d d d e g g e d c d e e e e d d e d c).

Verification
REQ-030 Reset, then pulse learn_song_button -> after the next frame_start+1 cycle, screen_sel=10, target_note=0000100 (e), note_idx=0, mistakes=0.
REQ-031 In LEARN at note_idx=0, press d -> mistakes=1, note_idx=0; press e -> note_idx=1, target_note=0000010 on the next frame.
REQ-032 Play all 26 correct notes -> song_done=1, screen_sel=11; after 120 frame_start pulses -> screen_sel=00.
REQ-033 Press c and d together at a c target -> mistakes+1, no advance; hold a key for 1000 cycles -> a single event.
REQ-034 Force 300 wrong presses -> mistakes=255; assert reset at note_idx=10 -> all outputs at reset values next cycle.
REQ-035 Pulse both buttons in the same cycle in HOME -> FREE (01); repeat in FREE -> HOME (00).
